// File: rtl/des_moore_fsm.sv
// des_moore_fsm: two-state Moore toggle FSM.
//   Each cycle with in = 0 flips the state; in = 1 holds it.
//   out is decoded from the state register only, so it never follows 'in' directly.
//
// Ports:
//   clk    in  1  rising-edge clock
//   reset  in  1  asynchronous, active-high; forces RESET_STATE immediately
//   in     in  1  FSM input, sampled on rising edge of clk
//   out    out 1  Moore output: OUT_B in state B, ~OUT_B in state A
//
// Parameters:
//   RESET_STATE  state entered on reset (1 = B, 0 = A)
//   OUT_B        value of out while in state B
module des_moore_fsm #(
  parameter logic RESET_STATE = 1'b1,
  parameter logic OUT_B       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  typedef enum logic {
    ST_A = 1'b0,
    ST_B = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register; reset takes effect without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and output decode; in = 0 toggles, in = 1 holds.
  always_comb begin
    state_d = state_q;
    out     = ~OUT_B;
    case (state_q)
      ST_A: begin
        out = ~OUT_B;
        if (!in) state_d = ST_B;
      end
      ST_B: begin
        out = OUT_B;
        if (!in) state_d = ST_A;
      end
      default: begin
        state_d = state_q;
        out     = ~OUT_B;
      end
    endcase
  end

endmodule

// File: tb/tb_des_moore_fsm.sv
// Testbench for des_moore_fsm: directed timeline checks plus a pseudo-random
// run against a reference model (next = reset ? B : state ^ ~in).
`timescale 1ns/100ps
module tb_des_moore_fsm;

  logic clk;
  logic reset;
  logic in;
  logic out;

  int tests;
  int fails;

  des_moore_fsm #(
    .RESET_STATE(1'b1),
    .OUT_B      (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .out  (out)
  );

  // Rising edges at 5, 15, 25, ... ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // t=0 -> 4.5: reset rises at 4 ns, out must be 1 before any edge.
  task automatic test_reset();
    #4 reset = 1'b1;
    #0.5;
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL reset_async: out=%b expected 1 at t=%0t", out, $time);
    end
  endtask

  // t=4.5 -> 24: reset held across edges at 5 and 15, in drops at 14.
  task automatic test_hold_under_reset();
    #1.5;
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold_edge5: out=%b expected 1", out);
    end
    #8 in = 1'b0;
    #2;
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold_edge15: out=%b expected 1", out);
    end
    #8;
  endtask

  // t=24 -> 36: release with in=0, toggle B->A at 25, A->B at 35.
  task automatic test_release_toggle();
    reset = 1'b0;
    in    = 1'b0;
    #0.5;
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL release_no_edge: out=%b expected 1", out);
    end
    #1.5;
    tests++;
    if (out !== 1'b0) begin
      fails++;
      $display("FAIL toggle_b_to_a: out=%b expected 0", out);
    end
    #10;
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL toggle_a_to_b: out=%b expected 1", out);
    end
  endtask

  // t=36 -> 106: hold in B for 3 edges, move to A, hold in A for 3 edges.
  task automatic test_hold();
    in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (out !== 1'b1) begin
        fails++;
        $display("FAIL hold_b_%0d: out=%b expected 1", i, out);
      end
    end
    in = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (out !== 1'b0) begin
      fails++;
      $display("FAIL enter_a: out=%b expected 0", out);
    end
    in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (out !== 1'b0) begin
        fails++;
        $display("FAIL hold_a_%0d: out=%b expected 0", i, out);
      end
    end
  endtask

  // t=106 -> 116: 2 ns reset pulse while in A, B retained afterwards.
  task automatic test_async_midrun_reset();
    #2 reset = 1'b1;
    #1;
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL midrun_pulse: out=%b expected 1", out);
    end
    #1 reset = 1'b0;
    #1;
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL midrun_after_release: out=%b expected 1", out);
    end
    @(posedge clk);
    #1;
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL midrun_retained_b: out=%b expected 1", out);
    end
  endtask

  // 200 cycles of LCG-driven in/reset checked against the reference model.
  task automatic test_random();
    logic        m;
    logic [31:0] lcg;
    m   = 1'b1;
    lcg = 32'h1234_5678;
    for (int c = 0; c < 200; c++) begin
      lcg   = lcg * 32'd1664525 + 32'd1013904223;
      in    = lcg[16];
      reset = (lcg[27:24] == 4'd0);
      #1;
      if (reset) m = 1'b1;
      tests++;
      if (out !== m) begin
        fails++;
        $display("FAIL rand_pre_%0d: out=%b expected %b", c, out, m);
      end
      @(posedge clk);
      m = reset ? 1'b1 : (m ^ ~in);
      #1;
      tests++;
      if (out !== m) begin
        fails++;
        $display("FAIL rand_edge_%0d: out=%b expected %b in=%b reset=%b", c, out, m, in, reset);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    in    = 1'b1;
    test_reset();
    test_hold_under_reset();
    test_release_toggle();
    test_hold();
    test_async_midrun_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
